// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master FSM state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ERRW, RESP} mst_state_t;

    // Size 3 is never legal; halfwords need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == 2'd3) ||
               (size == 2'd1 && addr_lo[0]) ||
               (size == 2'd2 && addr_lo != 2'd0);
    endfunction

endpackage

// File: rtl/ahb_lane_align.sv
// Byte-lane steering: store data replication and load data extraction.
module ahb_lane_align
    import ahb_pkg::*;
(
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_data,
    input  logic [1:0]  rd_size,
    input  logic [1:0]  rd_addr_lo,
    input  logic [31:0] rd_bus,
    output logic [31:0] wr_lanes,
    output logic [31:0] rd_data
);

    // Replicate the right-justified store data onto every lane it may occupy.
    always_comb begin
        wr_lanes = wr_data;
        case ({1'b0, wr_size})
            HSIZE_BYTE: wr_lanes = {4{wr_data[7:0]}};
            HSIZE_HALF: wr_lanes = {2{wr_data[15:0]}};
            default:    wr_lanes = wr_data;
        endcase
    end

    // Pull the addressed lane down to bit 0 and zero-extend.
    always_comb begin
        rd_data = rd_bus;
        case ({1'b0, rd_size})
            HSIZE_BYTE: begin
                case (rd_addr_lo)
                    2'd0:    rd_data = {24'h0, rd_bus[7:0]};
                    2'd1:    rd_data = {24'h0, rd_bus[15:8]};
                    2'd2:    rd_data = {24'h0, rd_bus[23:16]};
                    default: rd_data = {24'h0, rd_bus[31:24]};
                endcase
            end
            HSIZE_HALF: rd_data = rd_addr_lo[1] ? {16'h0, rd_bus[31:16]} : {16'h0, rd_bus[15:0]};
            default:    rd_data = rd_bus;
        endcase
    end

endmodule

// File: rtl/ahb_lite_master.sv
// Core load/store port to AHB-Lite single-beat master with misalign and timeout errors.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    mst_state_t  state;
    logic [31:0] haddr_q;
    logic [2:0]  hsize_q;
    logic        hwrite_q;
    logic [31:0] hwdata_q;
    logic [15:0] wait_cnt;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] wr_lanes;
    logic [31:0] rd_data;

    ahb_lane_align u_lane_align (
        .wr_size    (req_size),
        .wr_data    (req_wdata),
        .rd_size    (hsize_q[1:0]),
        .rd_addr_lo (haddr_q[1:0]),
        .rd_bus     (HRDATA),
        .wr_lanes   (wr_lanes),
        .rd_data    (rd_data)
    );

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign HTRANS    = (state == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = HBURST_SINGLE;
    assign HWDATA    = hwdata_q;

    // Transfer sequencer: request latch, bus phases, stall timeout and response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            haddr_q     <= 32'h0;
            hsize_q     <= HSIZE_BYTE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'h0;
            wait_cnt    <= 16'h0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                    if (req_valid) begin
                        if (is_misaligned(req_size, req_addr[1:0])) begin
                            // Rejected without touching the bus.
                            state     <= RESP;
                            rsp_err_q <= 1'b1;
                        end else begin
                            state    <= ADDR;
                            haddr_q  <= req_addr;
                            hsize_q  <= {1'b0, req_size};
                            hwrite_q <= req_write;
                            hwdata_q <= wr_lanes;
                            wait_cnt <= 16'h0;
                        end
                    end
                end
                ADDR: begin
                    if (HREADY) begin
                        state    <= DATA;
                        wait_cnt <= 16'h0;
                    end else if (wait_cnt == TO_LAST) begin
                        state     <= RESP;
                        rsp_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (HREADY) begin
                        state <= RESP;
                        if (HRESP == HRESP_ERROR) begin
                            // ERROR without the mandatory wait cycle; still an error.
                            rsp_err_q <= 1'b1;
                        end else begin
                            rsp_rdata_q <= hwrite_q ? 32'h0 : rd_data;
                        end
                    end else if (wait_cnt == TO_LAST) begin
                        state     <= RESP;
                        rsp_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                        if (HRESP == HRESP_ERROR) state <= ERRW;
                    end
                end
                ERRW: begin
                    if (HREADY || wait_cnt == TO_LAST) begin
                        state     <= RESP;
                        rsp_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESP: begin
                    state       <= IDLE;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Scoreboard bench for ahb_lite_master with a scripted AHB slave model.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    always #5 clk = ~clk;

    ahb_lite_master #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
        .HRESP(HRESP)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    // slave script
    int          cyc = 0;
    bit          slave_stall = 0;
    bit          slave_err_mode = 0;
    int          slave_waits = 0;
    logic [31:0] slave_rdata = 32'h0;

    // bus observations
    int          nonseq_cnt = 0;
    int          ns_first_cyc = -1;
    logic [31:0] obs_haddr;
    logic [2:0]  obs_hsize;
    logic        obs_hwrite;
    logic [31:0] obs_hwdata;

    // requester observations
    int          acc_cyc;
    logic        acc_ready;
    logic        acc_rsp_valid;

    // AHB slave: wait states, two-cycle ERROR, or permanent stall.
    initial begin
        bit   in_data;
        int   wcnt;
        int   ecnt;
        logic last_ns;
        logic last_rdy;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
        in_data = 0; wcnt = 0; ecnt = 0; last_ns = 1'b0; last_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (last_ns && last_rdy) begin
                in_data = 1; wcnt = slave_waits; ecnt = 0;
            end
            if (HTRANS == 2'b10) begin
                nonseq_cnt++;
                if (ns_first_cyc < 0) ns_first_cyc = cyc;
                obs_haddr = HADDR; obs_hsize = HSIZE; obs_hwrite = HWRITE;
            end
            HRESP = 1'b0; HRDATA = 32'h0; HREADY = 1'b1;
            if (slave_stall) begin
                HREADY = 1'b0;
            end else if (in_data) begin
                if (slave_err_mode) begin
                    HRESP  = 1'b1;
                    HREADY = (ecnt == 1);
                    if (ecnt == 1) in_data = 0;
                    ecnt++;
                end else if (wcnt > 0) begin
                    HREADY = 1'b0;
                    wcnt--;
                end else begin
                    HRDATA = slave_rdata;
                    obs_hwdata = HWDATA;
                    in_data = 0;
                end
            end
            last_ns  = (HTRANS == 2'b10);
            last_rdy = HREADY;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (total=%0d)", total_cnt);
        $fatal(1);
    end

    // Called at posedge+1; presents one request and returns at posedge+1 of cycle 1.
    task automatic send(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input int e_lat);
        exp_t x;
        x.err = e_err; x.rdata = e_rd; x.lat = e_lat;
        sb.push_back(x);
        nonseq_cnt = 0; ns_first_cyc = -1;
        obs_hwdata = 32'hxxxxxxxx;
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        @(negedge clk);
        acc_ready = req_ready; acc_rsp_valid = rsp_valid; acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    task automatic wait_rsp(input int budget, output bit got, output int lat,
                            output logic err, output logic [31:0] rd);
        got = 0; lat = 0; err = 1'b0; rd = 32'h0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1; lat = i; err = rsp_err; rd = rsp_rdata;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total_cnt++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got=%b exp=1", req_ready); else pass_cnt++;
        total_cnt++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
            $display("FAIL reset_rsp got v=%b e=%b d=%h exp 0/0/0", rsp_valid, rsp_err, rsp_rdata); else pass_cnt++;
        total_cnt++; if (HTRANS !== 2'b00 || HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'b000 || HWDATA !== 32'h0 || HBURST !== 3'b000)
            $display("FAIL reset_bus got tr=%b a=%h w=%b s=%b wd=%h b=%b exp all zero", HTRANS, HADDR, HWRITE, HSIZE, HWDATA, HBURST);
        else pass_cnt++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_word_read;
        exp_t x; bit got; int lat; logic err; logic [31:0] rd;
        slave_rdata = 32'hDEADBEEF;
        send(1'b0, 2'd2, 32'h08, 32'h0, 1'b0, 32'hDEADBEEF, 3);
        wait_rsp(20, got, lat, err, rd);
        x = sb.pop_front();
        total_cnt++; if (acc_ready !== 1'b1) $display("FAIL wr08_accept req_ready=%b exp=1", acc_ready); else pass_cnt++;
        total_cnt++; if (ns_first_cyc - acc_cyc !== 1 || nonseq_cnt !== 1)
            $display("FAIL wr08_nonseq cycle=%0d count=%0d exp cycle=1 count=1", ns_first_cyc - acc_cyc, nonseq_cnt); else pass_cnt++;
        total_cnt++; if (obs_haddr !== 32'h08 || obs_hsize !== 3'b010 || obs_hwrite !== 1'b0)
            $display("FAIL wr08_addr_phase a=%h s=%b w=%b exp 00000008/010/0", obs_haddr, obs_hsize, obs_hwrite); else pass_cnt++;
        total_cnt++; if (!got || lat !== x.lat) $display("FAIL wr08_latency got=%0b lat=%0d exp lat=%0d", got, lat, x.lat); else pass_cnt++;
        total_cnt++; if (err !== x.err || rd !== x.rdata) $display("FAIL wr08_rsp err=%b data=%h exp err=%b data=%h", err, rd, x.err, x.rdata); else pass_cnt++;
    endtask

    task automatic test_lanes;
        // {write, size, addr, wdata, slave data, expected HWDATA, expected rdata}
        logic [31:0] tab [4][7];
        tab[0] = '{32'd1, 32'd0, 32'h13, 32'h000000A5, 32'h0,        32'hA5A5A5A5, 32'h0};
        tab[1] = '{32'd0, 32'd1, 32'h12, 32'h0,        32'h12345678, 32'h0,        32'h00001234};
        tab[2] = '{32'd0, 32'd0, 32'h11, 32'h0,        32'h12345678, 32'h0,        32'h00000056};
        tab[3] = '{32'd1, 32'd1, 32'h02, 32'h0000BEEF, 32'h0,        32'hBEEFBEEF, 32'h0};
        for (int i = 0; i < 4; i++) begin
            exp_t x; bit got; int lat; logic err; logic [31:0] rd;
            slave_rdata = tab[i][4];
            send(tab[i][0][0], tab[i][1][1:0], tab[i][2], tab[i][3], 1'b0, tab[i][6], 3);
            wait_rsp(20, got, lat, err, rd);
            x = sb.pop_front();
            total_cnt++; if (obs_haddr !== tab[i][2] || obs_hsize !== {1'b0, tab[i][1][1:0]} || obs_hwrite !== tab[i][0][0])
                $display("FAIL lane%0d_addr_phase a=%h s=%b w=%b exp a=%h s=%b w=%b", i, obs_haddr, obs_hsize, obs_hwrite,
                         tab[i][2], {1'b0, tab[i][1][1:0]}, tab[i][0][0]);
            else pass_cnt++;
            if (tab[i][0][0]) begin
                total_cnt++; if (obs_hwdata !== tab[i][5]) $display("FAIL lane%0d_hwdata got=%h exp=%h", i, obs_hwdata, tab[i][5]); else pass_cnt++;
            end
            total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
                $display("FAIL lane%0d_rsp got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", i, got, lat, err, rd, x.lat, x.err, x.rdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = 32'h06; sizes[0] = 2'd2;
        addrs[1] = 32'h01; sizes[1] = 2'd1;
        addrs[2] = 32'h00; sizes[2] = 2'd3;
        for (int i = 0; i < 3; i++) begin
            exp_t x; bit got; int lat; logic err; logic [31:0] rd;
            slave_rdata = 32'hFFFFFFFF;
            send(1'b0, sizes[i], addrs[i], 32'h0, 1'b1, 32'h0, 1);
            wait_rsp(20, got, lat, err, rd);
            x = sb.pop_front();
            total_cnt++; if (nonseq_cnt !== 0) $display("FAIL misalign%0d_bus nonseq_count=%0d exp=0", i, nonseq_cnt); else pass_cnt++;
            total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
                $display("FAIL misalign%0d_rsp got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", i, got, lat, err, rd, x.lat, x.err, x.rdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_wait_states;
        exp_t x; bit got; int lat; logic err; logic [31:0] rd;
        slave_waits = 3; slave_rdata = 32'hCAFEF00D;
        send(1'b0, 2'd2, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, 6);
        wait_rsp(20, got, lat, err, rd);
        slave_waits = 0;
        x = sb.pop_front();
        total_cnt++; if (!got || lat !== x.lat) $display("FAIL wait3_latency got=%0b lat=%0d exp lat=%0d", got, lat, x.lat); else pass_cnt++;
        total_cnt++; if (err !== x.err || rd !== x.rdata) $display("FAIL wait3_rsp err=%b data=%h exp err=%b data=%h", err, rd, x.err, x.rdata); else pass_cnt++;
    endtask

    task automatic test_slave_error;
        exp_t x; bit got; int lat; logic err; logic [31:0] rd;
        slave_err_mode = 1; slave_rdata = 32'h55555555;
        send(1'b0, 2'd2, 32'h24, 32'h0, 1'b1, 32'h0, 4);
        wait_rsp(20, got, lat, err, rd);
        slave_err_mode = 0;
        x = sb.pop_front();
        total_cnt++; if (nonseq_cnt !== 1) $display("FAIL hresp_err_bus nonseq_count=%0d exp=1", nonseq_cnt); else pass_cnt++;
        total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
            $display("FAIL hresp_err_rsp got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", got, lat, err, rd, x.lat, x.err, x.rdata);
        else pass_cnt++;
    endtask

    task automatic test_timeout;
        exp_t x; bit got; int lat; logic err; logic [31:0] rd;
        slave_stall = 1;
        send(1'b0, 2'd2, 32'h30, 32'h0, 1'b1, 32'h0, 9);
        wait_rsp(30, got, lat, err, rd);
        slave_stall = 0;
        x = sb.pop_front();
        total_cnt++; if (nonseq_cnt !== 8) $display("FAIL timeout_addr_cycles got=%0d exp=8", nonseq_cnt); else pass_cnt++;
        total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
            $display("FAIL timeout_rsp got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", got, lat, err, rd, x.lat, x.err, x.rdata);
        else pass_cnt++;
        slave_rdata = 32'h11223344;
        send(1'b0, 2'd2, 32'h34, 32'h0, 1'b0, 32'h11223344, 3);
        wait_rsp(20, got, lat, err, rd);
        x = sb.pop_front();
        total_cnt++; if (acc_ready !== 1'b1) $display("FAIL after_timeout_accept req_ready=%b exp=1", acc_ready); else pass_cnt++;
        total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
            $display("FAIL after_timeout_rsp got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", got, lat, err, rd, x.lat, x.err, x.rdata);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        exp_t x; bit got; int lat; logic err; logic [31:0] rd; int first_acc;
        send(1'b1, 2'd2, 32'h40, 32'h01020304, 1'b0, 32'h0, 3);
        first_acc = acc_cyc;
        wait_rsp(20, got, lat, err, rd);
        x = sb.pop_front();
        total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata || obs_hwdata !== 32'h01020304)
            $display("FAIL b2b_first got=%0b lat=%0d err=%b data=%h hwdata=%h exp lat=%0d err=0 data=0 hwdata=01020304",
                     got, lat, err, rd, obs_hwdata, x.lat);
        else pass_cnt++;
        slave_rdata = 32'h89ABCDEF;
        send(1'b0, 2'd2, 32'h44, 32'h0, 1'b0, 32'h89ABCDEF, 3);
        total_cnt++; if (acc_cyc - first_acc !== 4 || acc_ready !== 1'b1)
            $display("FAIL b2b_accept_cycle got=%0d ready=%b exp cycle=4 ready=1", acc_cyc - first_acc, acc_ready); else pass_cnt++;
        total_cnt++; if (acc_rsp_valid !== 1'b0) $display("FAIL b2b_rsp_one_cycle rsp_valid=%b exp=0", acc_rsp_valid); else pass_cnt++;
        wait_rsp(20, got, lat, err, rd);
        x = sb.pop_front();
        total_cnt++; if (!got || lat !== x.lat || err !== x.err || rd !== x.rdata)
            $display("FAIL b2b_second got=%0b lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h", got, lat, err, rd, x.lat, x.err, x.rdata);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        exp_t x; int seen;
        slave_waits = 3;
        send(1'b0, 2'd2, 32'h50, 32'h0, 1'b0, 32'h0, 6);
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (req_ready !== 1'b0 || HTRANS !== 2'b00) $display("FAIL rstmid_in_data ready=%b htrans=%b exp 0/00", req_ready, HTRANS); else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++; if (HTRANS !== 2'b00 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || HADDR !== 32'h0)
            $display("FAIL rstmid_immediate htrans=%b ready=%b rsp_valid=%b haddr=%h exp 00/1/0/0", HTRANS, req_ready, rsp_valid, HADDR);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        x = sb.pop_front();
        total_cnt++; if (seen !== 0) $display("FAIL rstmid_no_rsp rsp_valid_cycles=%0d exp=0 (dropped lat %0d)", seen, x.lat); else pass_cnt++;
        slave_waits = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_addr = 32'h0; req_wdata = 32'h0;
        test_reset;
        test_word_read;
        test_lanes;
        test_misaligned;
        test_wait_states;
        test_slave_error;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        test_word_read;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

Bridges the multicycle core's load/store port to the AHB-Lite bus. It is the initiator side of the transfers that bus slaves such as the data RAM (HSEL2) respond to. Each core request becomes exactly one single-beat AHB transfer: address phase, data phase, then a one-cycle registered response back to the core. Misaligned requests and hung slaves are turned into error responses so the core never stalls forever.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: wait-state cycles allowed per phase before the transfer is aborted with an error; legal range 2..65535.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core request valid.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal and reported as an error.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data, right-justified and zero-extended; 0 for stores and for errors.
- rsp_err  out  1  qualifies rsp_valid; set for misalignment, HRESP ERROR or timeout.
- HADDR  out  32  AHB address.
- HTRANS  out  2  IDLE (00) or NONSEQ (10) only.
- HWRITE  out  1  transfer direction.
- HSIZE  out  3  000, 001 or 010.
- HBURST  out  3  constant 000 (SINGLE).
- HWDATA  out  32  write data, driven during the data phase.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer ready.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

## Operation
- The FSM has five states: IDLE, ADDR, DATA, ERRW, RESP.
- IDLE: req_ready=1.
  - On acceptance, latch addr, size, write and wdata.
  - If the request is misaligned (size 1 with addr[0]=1, size 2 with addr[1:0]!=0, or size 3), go to RESP with err=1. No bus activity occurs.
  - Otherwise go to ADDR.
- ADDR: drive HTRANS=NONSEQ, HADDR, HWRITE and HSIZE from the latched request.
  - On HREADY=1, go to DATA.
- DATA: HTRANS=IDLE. HWDATA holds the store data replicated across byte lanes: byte → {4{b}}, halfword → {2{h}}.
  - HREADY=1 && HRESP=0: capture the read lane selected by addr[1:0] and go to RESP with err=0.
  - HREADY=0 && HRESP=1: go to ERRW.
- ERRW: wait for HREADY=1 (second cycle of the ERROR response), then go to RESP with err=1.
- Timeout: a 16-bit counter clears on entry to ADDR and DATA and increments on every HREADY=0 cycle in ADDR, DATA or ERRW. When it reaches TIMEOUT_CYCLES-1 while HREADY is still 0, go to RESP with err=1 and HTRANS=IDLE.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- Byte-lane extract on read:
  - byte: HRDATA[8*a+7:8*a], where a = addr[1:0].
  - halfword: HRDATA[16*addr[1]+15 : 16*addr[1]].

## Timing
- Reset values: IDLE state; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; HTRANS=00; HADDR=0; HWRITE=0; HSIZE=000; HWDATA=0; counter=0.
- All outputs are registered or decoded from the state register only; none depends combinationally on req_* or H* inputs.
- Zero-wait transfer: accept in cycle 0, ADDR in cycle 1, DATA in cycle 2, rsp_valid in cycle 3. The next request can be accepted in cycle 4.
- Misaligned request: rsp_valid in cycle 1.
- Each wait state (HREADY=0) adds one cycle to the phase it occurs in.
- req_valid is ignored outside IDLE; at most one transfer is outstanding.
- Reset asserted mid-transfer: all outputs return to their reset values immediately, HTRANS drops to IDLE, and no response is produced.

## Structure
- Package ahb_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF and HSIZE_WORD.
  - HRESP_OKAY and HRESP_ERROR.
  - HBURST_SINGLE.
  - typedef enum logic [2:0] mst_state_t {IDLE, ADDR, DATA, ERRW, RESP}.
- One sub-module, ahb_lane_align, is combinational and holds both the write replication and the read extraction by size and addr[1:0].

## Test plan
- Word read at 0x08 with a zero-wait slave returning 0xDEADBEEF → HTRANS=NONSEQ in cycle 1, rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte write of 0xA5 to 0x13 → HSIZE=000, HADDR=0x13, HWDATA=0xA5A5A5A5 in the data phase, rsp_err=0. A halfword read at 0x12 with HRDATA=0x12345678 → rsp_rdata=0x00001234.
- Word read at 0x06 → no NONSEQ on the bus, rsp_valid in cycle 1 with rsp_err=1 and rsp_rdata=0.
- Slave inserts 3 wait states in the data phase → rsp_valid in cycle 6. With HRESP ERROR for two cycles → rsp_err=1 and HTRANS=IDLE throughout.
- HREADY held at 0 with TIMEOUT_CYCLES=8 → rsp_err=1 after 8 stalled cycles; the next request is accepted normally.
- reset pulsed during DATA → HTRANS=00 and req_ready=1 immediately, and no rsp_valid is produced.
